// File: rtl/serial_pattern_gen.sv
// MSB-first word serializer with a logic-1 idle gap after each word.
// Counts the 0->1 transitions it emits on a, for cross-checking a "01" detector.
module serial_pattern_gen #(
    parameter int WIDTH     = 8,
    parameter int IDLE_BITS = 2,
    parameter int COUNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [WIDTH-1:0]   load_data,
    input  logic               cnt_clr,
    output logic               a,
    output logic               frame,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] edge_cnt
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [BW-1:0]    bit_cnt_reg;
    logic [GW-1:0]    gap_cnt_reg;

    logic a_next;
    logic rise;

    assign load_ready = (state_reg == IDLE);
    assign frame      = (state_reg == SHIFT);
    assign busy       = (state_reg != IDLE);

    // Value a takes on this strobe, and whether that is a rising transition.
    always_comb begin
        a_next = a;
        if (en) begin
            if (state_reg == SHIFT) begin
                a_next = shreg_reg[WIDTH-1];
            end else if (state_reg == GAP) begin
                a_next = 1'b1;
            end
        end
        rise = ~a & a_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            a           <= 1'b1;
            done        <= 1'b0;
            edge_cnt    <= '0;
        end else begin
            done <= 1'b0;
            a    <= a_next;

            case (state_reg)
                IDLE: begin
                    if (load_valid) begin
                        shreg_reg   <= load_data;
                        bit_cnt_reg <= BW'(WIDTH - 1);
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (en) begin
                        shreg_reg <= {shreg_reg[WIDTH-2:0], 1'b0};
                        if (bit_cnt_reg == '0) begin
                            gap_cnt_reg <= GW'(IDLE_BITS - 1);
                            state_reg   <= GAP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg - BW'(1);
                        end
                    end
                end
                GAP: begin
                    if (en) begin
                        if (gap_cnt_reg == '0) begin
                            state_reg <= IDLE;
                            done      <= 1'b1;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg - GW'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Clear has priority over a coincident edge.
            if (cnt_clr) begin
                edge_cnt <= '0;
            end else if (rise) begin
                edge_cnt <= edge_cnt + COUNT_W'(1);
            end
        end
    end

endmodule
